// File: rtl/dmem_block_ctrl_pkg.sv
// Shared memory-system definitions: word/line widths and the block-controller FSM encoding.
package dmem_block_ctrl_pkg;
    localparam int DMEM_WORD_W  = 16;
    localparam int DMEM_BLOCK_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/dmem_block_ram.sv
// Single-port block storage: synchronous write, combinational read, no reset.
module dmem_block_ram #(
    parameter int IDX_W   = 8,
    parameter int BLOCK_W = 64
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    output logic [BLOCK_W-1:0] rdata_o
);
    logic [BLOCK_W-1:0] mem_q [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/dmem_block_ctrl.sv
// Data-memory block controller: one outstanding line read or write-back with fixed latency.
module dmem_block_ctrl
    import dmem_block_ctrl_pkg::*;
#(
    parameter int WORD_W  = DMEM_WORD_W,
    parameter int BLOCK_W = DMEM_BLOCK_W,
    parameter int IDX_W   = 8,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [WORD_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [BLOCK_W-1:0] rsp_rdata,
    output logic               wr_done,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
);
    dmem_state_e        state_q;
    logic               wr_op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [3:0]         lat_q;
    logic               ready_q, rsp_valid_q, wr_done_q;
    logic [BLOCK_W-1:0] rsp_rdata_q;
    logic [15:0]        rd_cnt_q, wr_cnt_q;

    logic               accept, op_wr, enter_done, ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [BLOCK_W-1:0] ram_wdata, ram_rdata;
    logic               unused_addr;

    assign unused_addr = ^{req_addr[WORD_W-1:IDX_W+2], req_addr[1:0]};

    // In IDLE the live request feeds the RAM so LATENCY=1 can complete on the accepting edge.
    always_comb begin
        accept     = (state_q == ST_IDLE) && (req_read || req_write);
        op_wr      = (state_q == ST_IDLE) ? req_write : wr_op_q;
        ram_idx    = (state_q == ST_IDLE) ? req_addr[IDX_W+1:2] : idx_q;
        ram_wdata  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
        enter_done = (accept && (LATENCY == 1)) || ((state_q == ST_WAIT) && (lat_q == 4'd1));
        ram_we     = reset_n && enter_done && op_wr;
    end

    dmem_block_ram #(.IDX_W(IDX_W), .BLOCK_W(BLOCK_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_op_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done_q   <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    wr_op_q <= req_write;
                    idx_q   <= req_addr[IDX_W+1:2];
                    wdata_q <= req_wdata;
                    lat_q   <= 4'(LATENCY);
                    ready_q <= 1'b0;
                    state_q <= (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_q == 4'd1) state_q <= ST_DONE;
                    else               lat_q   <= lat_q - 4'd1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    if (wr_op_q) wr_cnt_q <= wr_cnt_q + 16'd1;
                    else         rd_cnt_q <= rd_cnt_q + 16'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (enter_done) begin
                if (op_wr) begin
                    wr_done_q <= 1'b1;
                end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr_done   = wr_done_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
endmodule

// File: tb/tb_dmem_block_ctrl.sv
// Bench for dmem_block_ctrl: directed vector table, corner sequences, random ops vs. a line-array model.
module tb_dmem_block_ctrl;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready, rsp_valid, wr_done;
    logic [63:0] rsp_rdata;
    logic [15:0] rd_cnt, wr_cnt;

    int errors = 0;
    int checks = 0;

    // reference model: line array plus completion counters
    logic [63:0] mem_m [256];
    bit          known_m [256];
    logic [15:0] rd_cnt_m = '0, wr_cnt_m = '0;

    dmem_block_ctrl #(.WORD_W(16), .BLOCK_W(64), .IDX_W(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request from IDLE and follow it to the cycle after DONE, checking every cycle.
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [63:0] wd, input bit poke,
                         output logic got_valid, output logic [63:0] got_rdata,
                         output logic got_wrdone);
        int          idx;
        logic [63:0] exp_line;
        bit          is_wr;
        idx      = int'(addr[9:2]);
        is_wr    = wr;
        exp_line = mem_m[idx];
        got_valid = 1'b0; got_rdata = '0; got_wrdone = 1'b0;
        @(negedge clk);
        chk("ready_before_req", 64'(req_ready), 64'd1);
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0;
        req_addr = 16'($urandom); req_wdata = {$urandom, $urandom};
        if (is_wr) begin mem_m[idx] = wd; known_m[idx] = 1'b1; end
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (poke && c == 0) begin
                req_write = 1'b1; req_read = 1'b1; req_addr = 16'h0040; req_wdata = 64'hBAAD_BAAD_BAAD_BAAD;
            end else if (poke && c == 1) begin
                req_write = 1'b0; req_read = 1'b0;
            end
            if (c == LAT + 1) begin
                if (is_wr) wr_cnt_m++; else rd_cnt_m++;
            end
            chk("req_ready", 64'(req_ready), 64'(c == LAT + 1));
            chk("rsp_valid", 64'(rsp_valid), 64'(c == LAT && !is_wr));
            chk("wr_done",   64'(wr_done),   64'(c == LAT && is_wr));
            chk("rsp_rdata", rsp_rdata, (c == LAT && !is_wr) ? exp_line : 64'd0);
            chk("rd_cnt",    64'(rd_cnt),    64'(rd_cnt_m));
            chk("wr_cnt",    64'(wr_cnt),    64'(wr_cnt_m));
            if (c == LAT) begin got_valid = rsp_valid; got_rdata = rsp_rdata; got_wrdone = wr_done; end
        end
    endtask

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic        exp_valid;
        logic [63:0] exp_rdata;
        logic        exp_wrdone;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic        gv, gw;
        logic [63:0] gr;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 64'h1111_2222_3333_4444, 1'b0, 64'd0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 16'h0013, 64'd0, 1'b1, 64'h1111_2222_3333_4444, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0020, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'd0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0020, 64'd0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0404, 64'h0BAD_F00D_1234_5678, 1'b0, 64'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0004, 64'd0, 1'b1, 64'h0BAD_F00D_1234_5678, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0040, 64'h4040_4040_4040_4040, 1'b0, 64'd0, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_wrdone", 64'(wr_done), 64'd0);
        chk("rst_rdcnt", 64'(rd_cnt), 64'd0);
        chk("rst_wrcnt", 64'(wr_cnt), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, gv, gr, gw);
            chk("vec_valid", 64'(gv), 64'(vecs[i].exp_valid));
            chk("vec_rdata", gr, vecs[i].exp_rdata);
            chk("vec_wrdone", 64'(gw), 64'(vecs[i].exp_wrdone));
            if (i == 1) begin
                chk("vec_wrcnt_1", 64'(wr_cnt), 64'd1);
                chk("vec_rdcnt_1", 64'(rd_cnt), 64'd1);
            end
        end
        chk("both_high_rdcnt", 64'(rd_cnt), 64'd3);

        // write pulsed while busy is dropped
        do_op(1'b0, 1'b1, 16'h0080, 64'h8080_0000_8080_0000, 1'b1, gv, gr, gw);
        do_op(1'b1, 1'b0, 16'h0040, 64'd0, 1'b0, gv, gr, gw);
        chk("busy_ignored", gr, 64'h4040_4040_4040_4040);

        // reset two cycles into a write aborts it
        do_op(1'b0, 1'b1, 16'h0050, 64'h5050_5050_0000_0050, 1'b0, gv, gr, gw);
        @(negedge clk);
        req_write = 1'b1; req_addr = 16'h0050; req_wdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        req_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        rd_cnt_m = '0; wr_cnt_m = '0;
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_wrdone", 64'(wr_done), 64'd0);
        chk("abort_wrcnt", 64'(wr_cnt), 64'd0);
        chk("abort_rdcnt", 64'(rd_cnt), 64'd0);
        reset_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            chk("abort_no_wrdone", 64'(wr_done), 64'd0);
            chk("abort_no_valid", 64'(rsp_valid), 64'd0);
        end
        do_op(1'b1, 1'b0, 16'h0050, 64'd0, 1'b0, gv, gr, gw);
        chk("abort_old_line", gr, 64'h5050_5050_0000_0050);

        // random traffic; reads only target lines the model knows
        for (int n = 0; n < 200; n++) begin
            logic        r, w;
            logic [15:0] a;
            logic [63:0] d;
            a = 16'($urandom);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       begin r = 1'b1; w = 1'b0; end
                1:       begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            if (!w && !known_m[int'(a[9:2])]) w = 1'b1;
            do_op(r, w, a, d, ($urandom_range(0, 7) == 0), gv, gr, gw);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_block_ctrl.md
DMEM_BLOCK_CTRL -- requirements
Module: dmem_block_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, CPU word width in bits.
REQ-002 SHALL have parameter BLOCK_W, default 64, cache-line width in bits (4 words).
REQ-003 SHALL have parameter IDX_W, default 8, block-index width; storage depth is 2**IDX_W blocks.
REQ-004 SHALL have parameter LATENCY, default 4, memory access latency in cycles; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_read, input, 1, block-read request from the data cache.
REQ-008 SHALL have port req_write, input, 1, block write-back request from the data cache.
REQ-009 SHALL have port req_addr, input, WORD_W, word address of the request.
REQ-010 SHALL have port req_wdata, input, BLOCK_W, write-back line.
REQ-011 SHALL have port req_ready, output, 1, high when a request can be accepted.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle pulse qualifying rsp_rdata.
REQ-013 SHALL have port rsp_rdata, output, BLOCK_W, read line.
REQ-014 SHALL have port wr_done, output, 1, one-cycle pulse on write commit.
REQ-015 SHALL have ports rd_cnt and wr_cnt, output, 16 each, counts of completed reads and writes.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-017 SHALL drive req_ready high only in IDLE.
REQ-018 SHALL, in IDLE with req_read or req_write high, accept at that edge: latch op, req_addr[IDX_W+1:2] as index, req_wdata; load latency counter; leave IDLE.
REQ-019 SHALL ignore req_addr[1:0] and bits above IDX_W+1; addresses alias modulo 2**IDX_W blocks.
REQ-020 SHALL give write priority when req_read and req_write are both high at acceptance; the read is not queued.
REQ-021 SHALL ignore requests while not in IDLE; latched address and data stay stable.
REQ-022 SHALL make the response cycle, DONE, exactly LATENCY cycles after the accepting edge; LATENCY=1 goes IDLE to DONE directly.
REQ-023 SHALL, for reads in DONE, drive rsp_valid=1 and rsp_rdata = stored line for one cycle.
REQ-024 SHALL drive rsp_rdata to zero whenever rsp_valid is low.
REQ-025 SHALL, for writes, commit the line to storage on the edge entering DONE and assert wr_done in DONE for one cycle.
REQ-026 SHALL return from DONE to IDLE unconditionally; the next request can be accepted at the earliest in the cycle after DONE.
REQ-027 SHALL update rd_cnt or wr_cnt by one on the edge leaving DONE, wrapping 16'hFFFF to 0.
REQ-028 SHALL return, for a read issued after a completed write to the same index, the written line.

Reset
REQ-029 SHALL, with reset_n low at an edge, force IDLE, clear counter and latched request, and set req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0, rd_cnt=0, wr_cnt=0.
REQ-030 SHALL abort an in-flight request on reset, with no storage write and no response pulse.
REQ-031 SHALL leave storage contents unaffected by reset.

Structure
REQ-032 SHALL take WORD_W, BLOCK_W and the FSM state encoding from the shared memory-system package used by the caches.
REQ-033 SHALL place storage in one sub-module, dmem_block_ram: single-port, synchronous write, combinational read, IDX_W-wide index.

Verification
REQ-034 SHALL cover: write 64'h1111_2222_3333_4444 to addr 16'h0010, then read addr 16'h0013 -> wr_done, then rsp_valid with that line; wr_cnt=1, rd_cnt=1.
REQ-035 SHALL cover: LATENCY=4, read accepted at edge k -> rsp_valid high only in the cycle after edge k+4; req_ready low in between.
REQ-036 SHALL cover: req_read and req_write both high with addr 16'h0020 -> write performed, no rsp_valid, rd_cnt unchanged.
REQ-037 SHALL cover: a second write to 16'h0040 pulsed while busy -> ignored; later read of 16'h0040 returns prior contents.
REQ-038 SHALL cover: reset_n low two cycles after accepting a write of 64'hDEAD_BEEF_0000_0001 to 16'h0050 -> no wr_done; read of 16'h0050 returns old line.
REQ-039 SHALL cover: IDX_W=8, write to 16'h0404, read 16'h0004 -> same line returned (aliasing).
